// File: rtl/axis_tile_loader.sv
// axis_tile_loader: FIFO-buffered 8-bit stream packed into ROW_ELEMS-wide operand rows, framed by a byte count.
// Optional: define TILE_LOADER_ZERO_PAD_EN to emit the final partial row zero-padded instead of dropping it.
`timescale 1ns/1ps
module axis_tile_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_ELEMS  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_start,
  input  logic [15:0]                     cfg_len,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  output logic                            row_valid,
  input  logic                            row_ready,
  output logic [DATA_WIDTH*ROW_ELEMS-1:0] row_data,
  output logic                            row_last,
  output logic                            busy,
  output logic                            done
);
  localparam int ROW_W  = DATA_WIDTH * ROW_ELEMS;
  localparam int ELEM_W = $clog2(ROW_ELEMS) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [ELEM_W-1:0] ELEM_LAST     = ELEM_W'(ROW_ELEMS - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;
  state_t state_reg;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_cnt_reg;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  logic [15:0]       len_reg;
  logic [15:0]       acc_cnt_reg;
  logic [15:0]       pop_cnt_reg;
  logic [ELEM_W-1:0] elem_cnt_reg;
  logic [ROW_W-1:0]  pack_reg;
  logic [ROW_W-1:0]  pack_merged;
  logic [ROW_W-1:0]  row_data_reg;
  logic              row_valid_reg;
  logic              row_last_reg;
  logic              busy_reg;
  logic              done_reg;

  logic row_full;
  logic job_last_pop;
  logic emit_now;
  logic drop_now;
  logic last_row_pop;

  // tready uses the registered full flag, so a pop on a full FIFO frees the slot one cycle later
  assign fifo_full     = (fifo_cnt_reg == FIFO_FULL_CNT);
  assign fifo_empty    = (fifo_cnt_reg == '0);
  assign s_axis_tready = busy_reg && !fifo_full && (acc_cnt_reg < len_reg);
  assign fifo_wr       = s_axis_tvalid && s_axis_tready;
  assign fifo_rd       = (state_reg == LOAD) && !fifo_empty;
  assign fifo_rd_data  = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_reg] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (fifo_rd) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // Pack register with the popped byte dropped into lane elem_cnt
  genvar gi;
  generate
    for (gi = 0; gi < ROW_ELEMS; gi++) begin : g_lane
      assign pack_merged[gi*DATA_WIDTH +: DATA_WIDTH] =
        (elem_cnt_reg == ELEM_W'(gi)) ? fifo_rd_data : pack_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign row_full     = (elem_cnt_reg == ELEM_LAST);
  assign job_last_pop = (pop_cnt_reg == (len_reg - 16'd1));

`ifdef TILE_LOADER_ZERO_PAD_EN
  assign emit_now     = row_full || job_last_pop;
  assign drop_now     = 1'b0;
  assign last_row_pop = job_last_pop;
`else
  localparam logic [16:0] ROW_ELEMS_17 = 17'(ROW_ELEMS);
  assign emit_now     = row_full;
  assign drop_now     = job_last_pop && !row_full;
  // Last full row: no further complete row fits in the remaining length
  assign last_row_pop = (({1'b0, pop_cnt_reg} + ROW_ELEMS_17) >= {1'b0, len_reg});
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      acc_cnt_reg   <= '0;
      pop_cnt_reg   <= '0;
      elem_cnt_reg  <= '0;
      pack_reg      <= '0;
      row_data_reg  <= '0;
      row_valid_reg <= 1'b0;
      row_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (fifo_wr) begin
        acc_cnt_reg <= acc_cnt_reg + 16'd1;
      end
      case (state_reg)
        IDLE: begin
          if (cfg_start) begin
            len_reg      <= cfg_len;
            acc_cnt_reg  <= '0;
            pop_cnt_reg  <= '0;
            elem_cnt_reg <= '0;
            pack_reg     <= '0;
            if (cfg_len != 16'd0) begin
              busy_reg  <= 1'b1;
              state_reg <= LOAD;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        LOAD: begin
          if (fifo_rd) begin
            pack_reg     <= pack_merged;
            elem_cnt_reg <= elem_cnt_reg + 1'b1;
            pop_cnt_reg  <= pop_cnt_reg + 16'd1;
            if (emit_now) begin
              row_data_reg  <= pack_merged;
              row_valid_reg <= 1'b1;
              row_last_reg  <= last_row_pop;
              state_reg     <= EMIT;
            end else if (drop_now) begin
              pack_reg     <= '0;
              elem_cnt_reg <= '0;
              busy_reg     <= 1'b0;
              done_reg     <= 1'b1;
              state_reg    <= DONE;
            end
          end
        end
        EMIT: begin
          if (row_ready) begin
            row_valid_reg <= 1'b0;
            row_last_reg  <= 1'b0;
            pack_reg      <= '0;
            elem_cnt_reg  <= '0;
            if (pop_cnt_reg == len_reg) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              state_reg <= LOAD;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign row_valid = row_valid_reg;
  assign row_data  = row_data_reg;
  assign row_last  = row_last_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule
